// File: rtl/decoder_pkg.sv
// Shared types and memory-port constants for the decoder byte-to-word memory packer.
package decoder_pkg;

    localparam int MEM_AW = 13;
    localparam int MEM_DW = 32;
    localparam int BE_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/decoder_mem_packer.sv
// Packs a framed byte stream into 32-bit words and writes them to on-chip memory from BASE_ADDR.
// Define DECODER_PACKER_BSWAP_EN to place the first byte of each word in the most significant lane.
module decoder_mem_packer
    import decoder_pkg::*;
#(
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 5120
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_sop,
    input  logic              in_eop,
    output logic              in_ready,
    output logic [MEM_AW-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic [MEM_DW-1:0] mem_writedata,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic              frame_done,
    output logic [MEM_AW-1:0] frame_words,
    output logic              overflow
);

    localparam logic [MEM_AW-1:0] BASE_W  = MEM_AW'(BASE_ADDR);
    localparam logic [MEM_AW:0]   DEPTH_W = (MEM_AW + 1)'(DEPTH);

    function automatic logic [MEM_DW-1:0] place_byte(input logic [MEM_DW-1:0] word,
                                                     input logic [1:0] lane,
                                                     input logic [7:0] data);
        logic [MEM_DW-1:0] w;
        logic [1:0]        slot;
        w = word;
`ifdef DECODER_PACKER_BSWAP_EN
        slot = 2'd3 - lane;
`else
        slot = lane;
`endif
        w[int'(slot)*8 +: 8] = data;
        return w;
    endfunction

    // Byte enables for a word whose last filled lane is 'lane'.
    function automatic logic [BE_W-1:0] lane_mask(input logic [1:0] lane);
        logic [BE_W-1:0] be;
        case (lane)
`ifdef DECODER_PACKER_BSWAP_EN
            2'd0:    be = 4'b1000;
            2'd1:    be = 4'b1100;
            2'd2:    be = 4'b1110;
            default: be = 4'b1111;
`else
            2'd0:    be = 4'b0001;
            2'd1:    be = 4'b0011;
            2'd2:    be = 4'b0111;
            default: be = 4'b1111;
`endif
        endcase
        return be;
    endfunction

    state_e              state;
    logic [1:0]          lane_p0;
    logic [MEM_DW-1:0]   pack_p0;
    logic [MEM_AW:0]     cnt_p0;
    logic [MEM_AW-1:0]   ptr;
    logic                vld_p1;
    logic [MEM_DW-1:0]   word_p1;
    logic [BE_W-1:0]     be_p1;

    logic                accept;
    logic                start;
    logic                take;
    logic [1:0]          lane_base;
    logic [MEM_DW-1:0]   word_base;
    logic [MEM_DW-1:0]   word_nxt;
    logic                word_end;
    logic [MEM_AW:0]     cnt_base;
    logic                room;
    logic [MEM_AW:0]     cnt_nxt;

    assign in_ready = reset_n & (state != ST_DONE);
    assign accept   = in_valid & in_ready;
    assign start    = accept & in_sop;
    // A sop restarts the frame from any accepting state; other bytes only count while filling.
    assign take     = accept & (in_sop | (state == ST_FILL));

    always_comb begin
        lane_base = in_sop ? 2'd0 : lane_p0;
        word_base = (lane_base == 2'd0) ? '0 : pack_p0;
        word_nxt  = place_byte(word_base, lane_base, in_data);
        word_end  = take & ((lane_base == 2'd3) | in_eop);
        cnt_base  = in_sop ? '0 : cnt_p0;
        room      = (cnt_base < DEPTH_W);
        cnt_nxt   = cnt_base + (MEM_AW + 1)'(word_end & room);
    end

    // Stage p0: byte packing into the current word
    always_ff @(posedge clk) begin
        if (take) begin
            pack_p0 <= word_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            lane_p0     <= 2'd0;
            cnt_p0      <= '0;
            ptr         <= BASE_W;
            vld_p1      <= 1'b0;
            word_p1     <= '0;
            be_p1       <= '0;
            frame_done  <= 1'b0;
            frame_words <= '0;
            overflow    <= 1'b0;
        end else begin
            vld_p1     <= 1'b0;
            frame_done <= 1'b0;
            if (vld_p1) begin
                ptr <= ptr + 1'b1;
            end
            if (start) begin
                ptr      <= BASE_W;
                overflow <= 1'b0;
            end
            if (take) begin
                lane_p0 <= word_end ? 2'd0 : lane_base + 2'd1;
                cnt_p0  <= cnt_nxt;
                state   <= in_eop ? ST_DONE : ST_FILL;
                // Stage p1: completed word handed to the holding register for the write
                if (word_end) begin
                    if (room) begin
                        vld_p1  <= 1'b1;
                        word_p1 <= word_nxt;
                        be_p1   <= lane_mask(lane_base);
                    end else begin
                        overflow <= 1'b1;
                    end
                end
                if (in_eop) begin
                    frame_done  <= 1'b1;
                    frame_words <= cnt_nxt[MEM_AW-1:0];
                end
            end else if (state == ST_DONE) begin
                state <= ST_IDLE;
            end
        end
    end

    assign mem_address    = ptr;
    assign mem_writedata  = word_p1;
    assign mem_byteenable = be_p1;
    assign mem_write      = vld_p1;
    assign mem_chipselect = vld_p1;

endmodule
